// File: rtl/multiplier_4.sv
// Sequential signed multiplier: start captures A/B, Product/ready update nb cycles later.
// No backpressure: start is only accepted while ready is high and is ignored while busy.
module multiplier_4 #(
  parameter int nb = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [nb-1:0]   A,
  input  logic [nb-1:0]   B,
  output logic [2*nb-1:0] Product,
  output logic            ready
);

  localparam int W  = 2*nb + 1;
  localparam int CW = $clog2(nb + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   mcand_q;
  logic [nb-1:0]  mplier_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   acc_d;
  logic [W-1:0]   term;
  logic [CW-1:0]  cnt_q;
  logic           load;
  logic           step;
  logic           last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (cnt_q == CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    load  = 1'b0;
    step  = 1'b0;
    last  = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        load  = start;
      end
      BUSY: begin
        step = 1'b1;
        last = (cnt_q == CW'(1));
      end
      default: ready = 1'b0;
    endcase
  end

  // mcand_q already carries the weight of the current bit; the MSB carries negative weight.
  always_comb begin
    term  = mplier_q[0] ? mcand_q : '0;
    acc_d = last ? (acc_q - term) : (acc_q + term);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      mcand_q  <= {{(W-nb){A[nb-1]}}, A};
      mplier_q <= B;
      acc_q    <= '0;
      cnt_q    <= CW'(nb);
    end else if (step) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_d;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Product <= '0;
    end else if (last) begin
      Product <= acc_d[2*nb-1:0];
    end
  end

endmodule

// File: tb/tb_multiplier_4.sv
// Self-checking bench for multiplier_4 with an integer-arithmetic reference product.
module tb_multiplier_4;

  localparam int NB = 8;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [NB-1:0]   A;
  logic [NB-1:0]   B;
  logic [2*NB-1:0] Product;
  logic            ready;

  int checks;
  int errors;

  multiplier_4 #(.nb(NB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .Product (Product),
    .ready   (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2*NB-1:0] ref_mul(input logic [NB-1:0] a, input logic [NB-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[2*NB-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge, then leaves the operands undefined until completion.
  task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b);
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    A = 'x;
    B = 'x;
    repeat (NB) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    #12;
    checks++;
    if (Product !== '0) begin errors++; $display("FAIL reset_product got %h exp 0", Product); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    A = 8'h9C;
    B = 8'h4D;
    start = 1'b1;
    tick();
    start = 1'b0;
    A = 'x;
    B = 'x;
    repeat (3) tick();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_busy_ready got %b exp 0", ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || Product !== '0) begin
      errors++;
      $display("FAIL reset_async got ready=%b product=%h exp ready=1 product=0", ready, Product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (ready !== 1'b1 || Product !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got ready=%b product=%h exp ready=1 product=0", i, ready, Product);
      end
    end
  endtask

  task automatic test_basic();
    A = 8'd3;
    B = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    A = 'x;
    B = 'x;
    for (int i = 1; i < NB; i++) begin
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready_low after E0+%0d got %b exp 0", i - 1, ready); end
      checks++;
      if (Product !== '0) begin errors++; $display("FAIL basic_hold after E0+%0d got %h exp 0", i - 1, Product); end
      tick();
    end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready_low E0+7 got %b exp 0", ready); end
    tick();
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_done got %b exp 1", ready); end
    checks++;
    if (Product !== 16'h000F) begin errors++; $display("FAIL basic_product got %h exp 000f", Product); end
  endtask

  task automatic test_signs();
    logic [NB-1:0]   ta [5] = '{8'hF9, 8'h07, 8'h80, 8'h80, 8'h00};
    logic [NB-1:0]   tb [5] = '{8'h06, 8'hFA, 8'h80, 8'h7F, 8'hFF};
    logic [2*NB-1:0] te [5] = '{16'hFFD6, 16'hFFD6, 16'h4000, 16'hC080, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i]);
      checks++;
      if (Product !== te[i] || ready !== 1'b1) begin
        errors++;
        $display("FAIL signs_%0d %h*%h got %h ready=%b exp %h ready=1", i, ta[i], tb[i], Product, ready, te[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    A = 8'd10;
    B = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    A = 'x;
    B = 'x;
    repeat (2) tick();
    A = 8'd2;
    B = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    A = 'x;
    B = 'x;
    repeat (NB - 3) tick();
    checks++;
    if (Product !== 16'd100 || ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignore_done got %h ready=%b exp 0064 ready=1", Product, ready);
    end
    for (int i = 0; i < NB + 2; i++) begin
      tick();
      checks++;
      if (Product !== 16'd100 || ready !== 1'b1) begin
        errors++;
        $display("FAIL busy_ignore_after cyc %0d got %h ready=%b exp 0064 ready=1", i, Product, ready);
      end
    end
  endtask

  task automatic test_hold();
    run_op(8'd9, 8'hF7);
    checks++;
    if (Product !== 16'hFFAF) begin errors++; $display("FAIL hold_result got %h exp ffaf", Product); end
    for (int i = 0; i < 20; i++) begin
      A = NB'($urandom);
      B = NB'($urandom);
      tick();
      checks++;
      if (Product !== 16'hFFAF || ready !== 1'b1) begin
        errors++;
        $display("FAIL hold cyc %0d got %h ready=%b exp ffaf ready=1", i, Product, ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a = NB'($urandom);
      b = NB'($urandom);
      A = a;
      B = b;
      tick();
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL b2b_capture op %0d got ready=%b exp 0", k, ready); end
      A = 'x;
      B = 'x;
      repeat (NB) tick();
      checks++;
      if (Product !== ref_mul(a, b) || ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b op %0d %h*%h got %h ready=%b exp %h ready=1", k, a, b, Product, ready, ref_mul(a, b));
      end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    for (int i = 0; i < 1000; i++) begin
      a = NB'($urandom);
      b = NB'($urandom);
      A = a;
      B = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      A = 'x;
      B = 'x;
      repeat (NB + 1) tick();
      checks++;
      if (Product !== ref_mul(a, b) || ready !== 1'b1) begin
        errors++;
        $display("FAIL random %0d %h*%h got %h ready=%b exp %h ready=1", i, a, b, Product, ready, ref_mul(a, b));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_signs();
    test_busy_ignore();
    test_hold();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
